prog_sequencer: RTL and testbench

PROG_SEQUENCER -- requirements
Module: prog_sequencer

---
 rtl/prog_sequencer.sv | 124 ++++++++++++
 tb/tb_prog_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// prog_sequencer: runs a batch of NPROG programs on a core, sequencing core reset,
// start, completion/timeout detection and per-program result reporting.
`default_nettype none

module prog_sequencer #(
  parameter int          NPROG   = 3,
  parameter int          RST_CYC = 4,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Go,
  input  logic        CoreAck,
  output logic        CoreReset,
  output logic        CoreStart,
  output logic [1:0]  ProgSel,
  output logic        Busy,
  output logic        ResultValid,
  output logic [1:0]  ResultIdx,
  output logic [15:0] ResultCycles,
  output logic        ResultTimeout,
  output logic        Done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_LAUNCH = 3'd2,
    S_RUN    = 3'd3,
    S_REPORT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [15:0] RST_LAST = 16'(RST_CYC - 1);
  localparam logic [1:0]  SEL_LAST = 2'(NPROG - 1);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  state_t      state, state_nx;
  logic [15:0] count, count_nx;
  logic [1:0]  sel, sel_nx;
  logic        res_load;
  logic [15:0] res_cycles_nx;
  logic        res_timeout_nx;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state         <= S_IDLE;
      count         <= '0;
      sel           <= '0;
      ResultIdx     <= '0;
      ResultCycles  <= '0;
      ResultTimeout <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      sel   <= sel_nx;
      if (res_load) begin
        ResultIdx     <= sel;
        ResultCycles  <= res_cycles_nx;
        ResultTimeout <= res_timeout_nx;
      end
    end
  end

  always_comb begin
    state_nx       = state;
    count_nx       = count;
    sel_nx         = sel;
    res_load       = 1'b0;
    res_cycles_nx  = count;
    res_timeout_nx = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (Go) begin
          state_nx = S_RST;
          sel_nx   = '0;
          count_nx = '0;
        end
      end
      S_RST: begin
        if (count >= RST_LAST) state_nx = S_LAUNCH;
        else                   count_nx = count + 16'd1;
      end
      S_LAUNCH: begin
        count_nx = '0;
        state_nx = S_RUN;
      end
      S_RUN: begin
        // Ack wins over a timeout landing in the same cycle.
        if (CoreAck) begin
          state_nx = S_REPORT;
          res_load = 1'b1;
        end else if (count >= TIMEOUT) begin
          state_nx       = S_REPORT;
          res_load       = 1'b1;
          res_cycles_nx  = TIMEOUT;
          res_timeout_nx = 1'b1;
        end else if (count != CNT_MAX) begin
          count_nx = count + 16'd1;
        end
      end
      S_REPORT: begin
        if (sel < SEL_LAST) begin
          sel_nx   = sel + 2'd1;
          count_nx = '0;
          state_nx = S_RST;
        end else begin
          state_nx = S_DONE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign CoreReset   = (state == S_RST);
  assign CoreStart   = (state == S_LAUNCH);
  assign ProgSel     = sel;
  assign Busy        = (state != S_IDLE) && (state != S_DONE);
  assign ResultValid = (state == S_REPORT);
  assign Done        = (state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed bench with a result scoreboard for three parameterisations.
`default_nettype none

module tb_prog_sequencer;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] cyc;
    logic        to;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   a_starts = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  logic a_go, a_ack, a_creset, a_start, a_busy, a_valid, a_to, a_done;
  logic [1:0] a_sel, a_idx;
  logic [15:0] a_cyc;
  logic b_go, b_ack, b_creset, b_start, b_busy, b_valid, b_to, b_done;
  logic [1:0] b_sel, b_idx;
  logic [15:0] b_cyc;
  logic c_go, c_ack, c_creset, c_start, c_busy, c_valid, c_to, c_done;
  logic [1:0] c_sel, c_idx;
  logic [15:0] c_cyc;

  logic [25:0] a_all, b_all, c_all;
  assign a_all = {a_creset, a_start, a_sel, a_busy, a_valid, a_idx, a_cyc, a_to, a_done};
  assign b_all = {b_creset, b_start, b_sel, b_busy, b_valid, b_idx, b_cyc, b_to, b_done};
  assign c_all = {c_creset, c_start, c_sel, c_busy, c_valid, c_idx, c_cyc, c_to, c_done};

  prog_sequencer dut_a (
    .Clk(clk), .Reset(rst_n), .Go(a_go), .CoreAck(a_ack),
    .CoreReset(a_creset), .CoreStart(a_start), .ProgSel(a_sel), .Busy(a_busy),
    .ResultValid(a_valid), .ResultIdx(a_idx), .ResultCycles(a_cyc),
    .ResultTimeout(a_to), .Done(a_done)
  );

  prog_sequencer #(.NPROG(3), .RST_CYC(4), .TIMEOUT(16'd20)) dut_b (
    .Clk(clk), .Reset(rst_n), .Go(b_go), .CoreAck(b_ack),
    .CoreReset(b_creset), .CoreStart(b_start), .ProgSel(b_sel), .Busy(b_busy),
    .ResultValid(b_valid), .ResultIdx(b_idx), .ResultCycles(b_cyc),
    .ResultTimeout(b_to), .Done(b_done)
  );

  prog_sequencer #(.NPROG(1), .RST_CYC(4), .TIMEOUT(16'd5)) dut_c (
    .Clk(clk), .Reset(rst_n), .Go(c_go), .CoreAck(c_ack),
    .CoreReset(c_creset), .CoreStart(c_start), .ProgSel(c_sel), .Busy(c_busy),
    .ResultValid(c_valid), .ResultIdx(c_idx), .ResultCycles(c_cyc),
    .ResultTimeout(c_to), .Done(c_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input int i, input int c, input bit t);
    res_t r;
    r.idx = 2'(i);
    r.cyc = 16'(c);
    r.to  = t;
    return r;
  endfunction

  task automatic check_res(input string tag, input logic [1:0] idx, input logic [15:0] cyc,
                           input logic to);
    res_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected_result"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_res_idx"}, 32'(idx), 32'(e.idx));
      chk({tag, "_res_cycles"}, 32'(cyc), 32'(e.cyc));
      chk({tag, "_res_timeout"}, 32'(to), 32'(e.to));
    end
  endtask

  always @(negedge clk) begin
    if (a_valid) check_res("a", a_idx, a_cyc, a_to);
    if (b_valid) check_res("b", b_idx, b_cyc, b_to);
    if (c_valid) check_res("c", c_idx, c_cyc, c_to);
    if (a_start) a_starts <= a_starts + 1;
    if (a_start && a_creset) chk("a_start_with_reset", 32'd1, 32'd0);
    if (b_start && b_creset) chk("b_start_with_reset", 32'd1, 32'd0);
  end

  // Waits for the next CoreReset window, then checks its length and the launch cycle.
  task automatic launch_a(input int i);
    int k;
    k = 0;
    while (!a_creset && k < 100) begin @(negedge clk); k++; end
    chk("a_prog_sel", 32'(a_sel), 32'(i));
    k = 0;
    while (a_creset && k < 100) begin @(negedge clk); k++; end
    chk("a_core_reset_len", 32'(k), 32'd4);
    chk("a_launch", 32'({a_start, a_creset}), 32'b10);
  endtask

  // Called at the LAUNCH sample point; acks in the RUN cycle whose count equals n.
  task automatic run_a(input int n, input bit hold, input bit tog);
    a_ack = hold;
    repeat (n + 1) begin
      @(negedge clk);
      if (tog) a_go = ~a_go;
    end
    a_ack = 1'b1;
    a_go  = 1'b0;
    @(negedge clk);
    a_ack = hold;
  endtask

  initial begin
    int k;
    int s0;
    rst_n = 1'b0;
    a_go = 1'b0; a_ack = 1'b0;
    b_go = 1'b0; b_ack = 1'b0;
    c_go = 1'b0; c_ack = 1'b0;
    #1;
    chk("a_reset_outs", 32'(a_all), 32'd0);
    chk("b_reset_outs", 32'(b_all), 32'd0);
    chk("c_reset_outs", 32'(c_all), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("a_idle_outs", 32'(a_all), 32'd0);

    // Core never acks: every program is abandoned at TIMEOUT.
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(i, 20, 1'b1));
    b_go = 1'b1;
    @(negedge clk);
    b_go = 1'b0;
    k = 0;
    while (!b_done && k < 300) begin @(negedge clk); k++; end
    chk("b_done_busy", 32'({b_done, b_busy}), 32'b10);
    chk("b_queue_drained", 32'(exp_q.size()), 32'd0);

    // Ack lands in the same cycle the timeout would fire.
    exp_q.push_back(mk(0, 5, 1'b0));
    c_go = 1'b1;
    @(negedge clk);
    c_go = 1'b0;
    k = 0;
    while (!c_start && k < 50) begin @(negedge clk); k++; end
    chk("c_launch", 32'(c_start), 32'd1);
    c_ack = 1'b0;
    repeat (6) @(negedge clk);
    c_ack = 1'b1;
    @(negedge clk);
    c_ack = 1'b0;
    @(negedge clk);
    chk("c_done_busy", 32'({c_done, c_busy}), 32'b10);
    chk("c_queue_drained", 32'(exp_q.size()), 32'd0);

    // Nominal batch with acks after 10/25/7 RUN cycles.
    exp_q.push_back(mk(0, 10, 1'b0));
    exp_q.push_back(mk(1, 25, 1'b0));
    exp_q.push_back(mk(2, 7, 1'b0));
    a_go = 1'b1;
    @(negedge clk);
    a_go = 1'b0;
    launch_a(0); run_a(10, 1'b0, 1'b0);
    launch_a(1); run_a(25, 1'b0, 1'b0);
    launch_a(2); run_a(7, 1'b0, 1'b0);
    @(negedge clk);
    chk("a_done_busy", 32'({a_done, a_busy, a_valid}), 32'b100);
    chk("a_hold_idx", 32'(a_idx), 32'd2);
    chk("a_hold_cycles", 32'(a_cyc), 32'd7);
    chk("a_queue_drained", 32'(exp_q.size()), 32'd0);

    // CoreAck held high throughout.
    s0 = a_starts;
    a_ack = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(i, 0, 1'b0));
    a_go = 1'b1;
    @(negedge clk);
    a_go = 1'b0;
    chk("a_restart_from_done", 32'({a_done, a_busy, a_sel}), 32'b0100);
    for (int i = 0; i < 3; i++) begin launch_a(i); run_a(0, 1'b1, 1'b0); end
    @(negedge clk);
    a_ack = 1'b0;
    chk("a_done_ack_high", 32'(a_done), 32'd1);
    chk("a_start_pulses", 32'(a_starts - s0), 32'd3);

    // Go toggled while busy, then held in DONE.
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(i, 3, 1'b0));
    a_go = 1'b1;
    @(negedge clk);
    a_go = 1'b0;
    for (int i = 0; i < 3; i++) begin launch_a(i); run_a(3, 1'b0, 1'b1); end
    @(negedge clk);
    chk("a_done_after_toggle", 32'({a_done, a_busy}), 32'b10);
    a_go = 1'b1;
    @(negedge clk);
    chk("a_go_held_restart", 32'({a_done, a_busy, a_sel, a_creset}), 32'b01001);
    exp_q.push_back(mk(0, 4, 1'b0));
    launch_a(0); run_a(4, 1'b0, 1'b0);
    launch_a(1);

    // Asynchronous reset between edges in the middle of program 1's RUN.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("a_async_reset_outs", 32'(a_all), 32'd0);
    a_go = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("a_idle_after_reset", 32'(a_all), 32'd0);
    a_go = 1'b1;
    @(negedge clk);
    a_go = 1'b0;
    chk("a_restart_after_reset", 32'({a_busy, a_sel, a_creset}), 32'b1001);
    chk("a_no_stale_results", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
